clip_playback_reader: RTL

Read side of the team's audio clip buffer. Takes a clip of signed 16-bit samples already written into the dual-port clip RAM by the recorder, and plays it back one sample per `audio_valid_in` tick. It drives the RAM's read port and applies a shift attenuation. It supports one-shot and looped playback, start/restart/stop control and a done pulse, and feeds the same audio output mux as the echo path.

---
 rtl/clip_playback_reader_if.sv | 21 ++
 rtl/clip_playback_reader.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/clip_playback_reader_if.sv
// Read port of the dual-port clip RAM as seen by the playback reader.
// master = reader side, slave = RAM side.
interface clip_playback_reader_if #(
  parameter int ADDR_WIDTH = 17
);
  logic [ADDR_WIDTH-1:0] rd_addr_out;
  logic                  rd_en_out;
  logic [15:0]           rd_data_in;

  modport master (
    output rd_addr_out,
    output rd_en_out,
    input  rd_data_in
  );

  modport slave (
    input  rd_addr_out,
    input  rd_en_out,
    output rd_data_in
  );
endinterface

// File: rtl/clip_playback_reader.sv
// Clip buffer playback: fetches one sample per audio tick from the clip RAM,
// applies a shift attenuation, supports one-shot/loop, restart and stop.
module clip_playback_reader #(
  parameter int RAM_DEPTH    = 96000,
  parameter int ADDR_WIDTH   = 17,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  audio_valid_in,
  input  logic                  play_in,
  input  logic                  stop_in,
  input  logic                  loop_in,
  input  logic [ADDR_WIDTH-1:0] clip_len_in,
  input  logic [2:0]            atten_in,
  clip_playback_reader_if.master ram,
  output logic signed [15:0]    signal_out,
  output logic                  sample_valid_out,
  output logic                  busy_out,
  output logic                  done_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] DEPTH_W = ADDR_WIDTH'(RAM_DEPTH);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]   len_q, len_d;
  logic [READ_LATENCY-1:0] tok_q, tok_d;
  logic signed [15:0]      signal_q, signal_d;
  logic                    valid_q, valid_d;
  logic                    done_q, done_d;

  logic play_go;
  logic fetch;
  logic at_last;
  logic drain_end;

  // Stop beats play; play with an empty clip is ignored; a tick coinciding
  // with play is dropped so the first fetch uses the following tick.
  assign play_go   = play_in && !stop_in && (clip_len_in != '0);
  assign fetch     = audio_valid_in && (state_q == PLAY) && !stop_in && !play_go;
  assign at_last   = (addr_q == (len_q - ADDR_WIDTH'(1)));
  assign drain_end = (state_q == DRAIN) && (tok_q == '0) && valid_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      len_q    <= '0;
      tok_q    <= '0;
      signal_q <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      tok_q    <= tok_d;
      signal_q <= signal_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (stop_in) begin
      state_d = IDLE;
    end else if (play_go) begin
      state_d = PLAY;
    end else begin
      unique case (state_q)
        IDLE:    state_d = IDLE;
        PLAY:    if (fetch && at_last && !loop_in) state_d = DRAIN;
        DRAIN:   if (drain_end) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    addr_d   = addr_q;
    len_d    = len_q;
    tok_d    = tok_q << 1;
    tok_d[0] = fetch;
    signal_d = signal_q;
    valid_d  = 1'b0;
    done_d   = 1'b0;

    // The oldest token marks the cycle in which rd_data_in is valid.
    if (tok_q[READ_LATENCY-1]) begin
      valid_d  = 1'b1;
      signal_d = $signed(ram.rd_data_in) >>> atten_in;
    end

    if (fetch) begin
      if (!at_last) begin
        addr_d = addr_q + ADDR_WIDTH'(1);
      end else if (loop_in) begin
        addr_d = '0;
      end
    end

    if (drain_end) begin
      done_d   = 1'b1;
      signal_d = '0;
      addr_d   = '0;
    end

    if (play_go) begin
      len_d   = (clip_len_in > DEPTH_W) ? DEPTH_W : clip_len_in;
      addr_d  = '0;
      tok_d   = '0;
      valid_d = 1'b0;
      done_d  = 1'b0;
    end

    if (stop_in) begin
      tok_d    = '0;
      valid_d  = 1'b0;
      done_d   = 1'b0;
      signal_d = '0;
      addr_d   = '0;
    end
  end

  assign ram.rd_addr_out = addr_q;
  assign ram.rd_en_out   = (state_q != IDLE);
  assign busy_out        = (state_q != IDLE);
  assign signal_out      = signal_q;
  assign sample_valid_out = valid_q;
  assign done_out        = done_q;

endmodule
